// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: sequences PLL reset, lock qualification, and system reset release
// from a free-running reference clock, and restarts the sequence on timeout or lock loss.
module pll_lock_supervisor #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned LOCK_TIMEOUT  = 1000000,
    parameter int unsigned HOLD_CYCLES   = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       locked_in,
    input  logic       clr_lost,
    output logic       pll_rst,
    output logic       sys_reset,
    output logic       ready,
    output logic       lock_lost,
    output logic [7:0] retry_cnt
);

    // Shared counter must cover the longest interval any state measures.
    localparam int unsigned MaxA   = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
    localparam int unsigned MaxB   = (RST_CYCLES > HOLD_CYCLES) ? RST_CYCLES : HOLD_CYCLES;
    localparam int unsigned CntMax = (MaxA > MaxB) ? MaxA : MaxB;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned StabW  = $clog2(STABLE_CYCLES + 1);

    localparam logic [CntW-1:0]  RstLast  = CntW'(RST_CYCLES - 1);
    localparam logic [CntW-1:0]  TmoLast  = CntW'(LOCK_TIMEOUT - 1);
    localparam logic [CntW-1:0]  HoldLast = CntW'(HOLD_CYCLES - 1);
    localparam logic [StabW-1:0] StabLast = StabW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        StPrst,
        StWait,
        StHold,
        StRun
    } state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [StabW-1:0]       stab_q, stab_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [7:0]             retry_q, retry_d;
    logic                   pll_rst_q, pll_rst_d;
    logic                   sys_reset_q, sys_reset_d;
    logic                   ready_q, ready_d;
    logic                   lock_lost_q, lock_lost_d;
    logic                   lk_s;
    logic                   accept;
    logic                   set_lost;

    // Synchroniser shift chain for the asynchronous PLL locked pin.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], locked_in};
    end

    assign lk_s = sync_q[SYNC_STAGES-1];

    // Sequencing FSM: next state, shared counter, stability run and retry count.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stab_d   = stab_q;
        retry_d  = retry_q;
        accept   = 1'b0;
        set_lost = 1'b0;

        unique case (state_q)
            StPrst: begin
                if (cnt_q == RstLast) begin
                    cnt_d   = '0;
                    state_d = StWait;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StWait: begin
                cnt_d = cnt_q + 1'b1;
                if (lk_s) begin
                    if (stab_q == StabLast) begin
                        accept = 1'b1;
                    end else begin
                        stab_d = stab_q + 1'b1;
                    end
                end else begin
                    stab_d = '0;
                end

                // Acceptance takes priority over a coincident timeout.
                if (accept) begin
                    state_d = StHold;
                    cnt_d   = '0;
                    stab_d  = '0;
                end else if (cnt_q == TmoLast) begin
                    state_d = StPrst;
                    cnt_d   = '0;
                    stab_d  = '0;
                    if (retry_q != 8'hFF) begin
                        retry_d = retry_q + 8'd1;
                    end
                end
            end

            StHold: begin
                if (!lk_s) begin
                    state_d = StPrst;
                    cnt_d   = '0;
                end else if (cnt_q == HoldLast) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StRun: begin
                if (!lk_s) begin
                    state_d  = StPrst;
                    cnt_d    = '0;
                    set_lost = 1'b1;
                end
            end

            default: begin
                state_d = StPrst;
                cnt_d   = '0;
                stab_d  = '0;
            end
        endcase
    end

    // Registered outputs follow the state being entered so they change on the same edge.
    always_comb begin
        pll_rst_d   = (state_d == StPrst);
        sys_reset_d = (state_d != StRun);
        ready_d     = (state_d == StRun);
        // A loss in the same cycle as a clear keeps the flag set.
        if (set_lost) begin
            lock_lost_d = 1'b1;
        end else if (clr_lost) begin
            lock_lost_d = 1'b0;
        end else begin
            lock_lost_d = lock_lost_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StPrst;
            cnt_q       <= '0;
            stab_q      <= '0;
            sync_q      <= '0;
            retry_q     <= '0;
            pll_rst_q   <= 1'b1;
            sys_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stab_q      <= stab_d;
            sync_q      <= sync_d;
            retry_q     <= retry_d;
            pll_rst_q   <= pll_rst_d;
            sys_reset_q <= sys_reset_d;
            ready_q     <= ready_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_reset = sys_reset_q;
    assign ready     = ready_q;
    assign lock_lost = lock_lost_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed scenarios plus random lock activity, every cycle
// compared against a duration-based reference model.
module tb_pll_lock_supervisor;

    localparam int unsigned SYNC  = 2;
    localparam int unsigned RSTC  = 4;
    localparam int unsigned STAB  = 8;
    localparam int unsigned TMO   = 40;
    localparam int unsigned HOLDC = 5;

    localparam int PhPrst = 0;
    localparam int PhWait = 1;
    localparam int PhHold = 2;
    localparam int PhRun  = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       locked_in;
    logic       clr_lost;
    logic       pll_rst;
    logic       sys_reset;
    logic       ready;
    logic       lock_lost;
    logic [7:0] retry_cnt;

    always #5 clk = ~clk;

    pll_lock_supervisor #(
        .SYNC_STAGES  (SYNC),
        .RST_CYCLES   (RSTC),
        .STABLE_CYCLES(STAB),
        .LOCK_TIMEOUT (TMO),
        .HOLD_CYCLES  (HOLDC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .locked_in(locked_in),
        .clr_lost (clr_lost),
        .pll_rst  (pll_rst),
        .sys_reset(sys_reset),
        .ready    (ready),
        .lock_lost(lock_lost),
        .retry_cnt(retry_cnt)
    );

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: phase plus time spent in it, length of the current high run,
    // and a history of sampled locked_in values standing in for the synchroniser delay.
    int m_phase   = PhPrst;
    int m_elapsed = 0;
    int m_run     = 0;
    int m_retry   = 0;
    int m_edge    = 0;
    bit m_lost    = 0;
    bit hist[$];

    task automatic chk(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
    endtask

    task automatic model_step(input bit r, input bit lk, input bit clr);
        bit lks;
        bit set;
        if (r) begin
            m_phase = PhPrst; m_elapsed = 0; m_run = 0; m_retry = 0; m_lost = 0; m_edge = 0;
            hist.delete();
            return;
        end
        m_edge++;
        // locked_in as it was SYNC edges ago; zero until the chain has filled.
        lks = (hist.size() >= SYNC) ? hist[hist.size() - SYNC] : 1'b0;
        hist.push_back(lk);
        if (hist.size() > SYNC) void'(hist.pop_front());
        set = 0;
        case (m_phase)
            PhPrst: begin
                m_elapsed++;
                if (m_elapsed == RSTC) begin m_phase = PhWait; m_elapsed = 0; m_run = 0; end
            end
            PhWait: begin
                m_elapsed++;
                m_run = lks ? m_run + 1 : 0;
                if (m_run == STAB) begin
                    m_phase = PhHold; m_elapsed = 0;
                end else if (m_elapsed == TMO) begin
                    m_phase = PhPrst; m_elapsed = 0;
                    if (m_retry < 255) m_retry++;
                end
            end
            PhHold: begin
                if (!lks) begin
                    m_phase = PhPrst; m_elapsed = 0;
                end else begin
                    m_elapsed++;
                    if (m_elapsed == HOLDC) begin m_phase = PhRun; m_elapsed = 0; end
                end
            end
            default: begin
                if (!lks) begin m_phase = PhPrst; m_elapsed = 0; set = 1; end
            end
        endcase
        if (set) m_lost = 1;
        else if (clr) m_lost = 0;
    endtask

    // One clock: record applied inputs, advance model, compare every output.
    task automatic tick();
        bit r;
        bit lk;
        bit c;
        r  = reset;
        lk = locked_in;
        c  = clr_lost;
        @(posedge clk);
        #1;
        model_step(r, lk, c);
        chk("pll_rst",   pll_rst,   (m_phase == PhPrst) ? 1 : 0);
        chk("sys_reset", sys_reset, (m_phase != PhRun) ? 1 : 0);
        chk("ready",     ready,     (m_phase == PhRun) ? 1 : 0);
        chk("lock_lost", lock_lost, m_lost ? 1 : 0);
        chk("retry_cnt", retry_cnt, m_retry);
    endtask

    task automatic run_to(input int e);
        for (int i = 0; i < 20000 && m_edge < e; i++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int ready_seen;
        int left;
        reset     = 1'b1;
        locked_in = 1'b0;
        clr_lost  = 1'b0;

        // Nominal bring-up with locked_in high throughout.
        locked_in = 1'b1;
        do_reset();
        chk("t1_reset_pll_rst", pll_rst, 1);
        chk("t1_reset_sys_reset", sys_reset, 1);
        chk("t1_reset_retry", retry_cnt, 0);
        run_to(3);
        chk("t1_prst_e3", pll_rst, 1);
        run_to(4);
        chk("t1_wait_e4", pll_rst, 0);
        run_to(16);
        chk("t1_hold_e16_ready", ready, 0);
        chk("t1_hold_e16_sysrst", sys_reset, 1);
        run_to(17);
        chk("t1_run_e17_ready", ready, 1);
        chk("t1_run_e17_sysrst", sys_reset, 0);
        chk("t1_retry", retry_cnt, 0);

        // Lock loss in RUN, then a second loss coinciding with clr_lost.
        run_to(25);
        locked_in = 1'b0;
        tick();
        locked_in = 1'b1;
        tick();
        chk("t4_still_ready", ready, 1);
        tick();
        chk("t4_loss_ready", ready, 0);
        chk("t4_loss_sysrst", sys_reset, 1);
        chk("t4_loss_lost", lock_lost, 1);
        tick();
        chk("t4_repulse", pll_rst, 1);
        run_to(45);
        chk("t4_recovered", ready, 1);
        locked_in = 1'b0;
        tick();
        locked_in = 1'b1;
        tick();
        clr_lost = 1'b1;
        tick();
        clr_lost = 1'b0;
        chk("t4_set_beats_clr", lock_lost, 1);
        tick();
        clr_lost = 1'b1;
        tick();
        clr_lost = 1'b0;
        chk("t4_clr", lock_lost, 0);

        // Lock loss during HOLD.
        do_reset();
        run_to(11);
        locked_in = 1'b0;
        tick();
        locked_in = 1'b1;
        tick();
        chk("t5_hold1_pll_rst", pll_rst, 0);
        tick();
        chk("t5_back_prst", pll_rst, 1);
        chk("t5_lost", lock_lost, 0);
        chk("t5_retry", retry_cnt, 0);

        // Reset while in WAIT after two timeouts.
        locked_in = 1'b0;
        do_reset();
        run_to(101);
        chk("t6_retry_before", retry_cnt, 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_pll_rst", pll_rst, 1);
        chk("t6_sys_reset", sys_reset, 1);
        chk("t6_retry", retry_cnt, 0);
        run_to(4);
        chk("t6_restart_wait", pll_rst, 0);

        // Unstable lock: 6 high, 1 low repeatedly, then steady.
        do_reset();
        ready_seen = 0;
        for (int k = 1; k <= 90; k++) begin
            locked_in = ((k % 7) < 6);
            tick();
            if (ready) ready_seen++;
        end
        chk("t3_never_ready", ready_seen, 0);
        chk("t3_retry", retry_cnt, 2);
        locked_in = 1'b1;
        run_to(150);
        chk("t3_accepted", ready, 1);

        // Lock timeouts until saturation.
        locked_in = 1'b0;
        do_reset();
        run_to(43);
        chk("t2_e43_retry", retry_cnt, 0);
        chk("t2_e43_pll_rst", pll_rst, 0);
        run_to(44);
        chk("t2_e44_retry", retry_cnt, 1);
        chk("t2_e44_pll_rst", pll_rst, 1);
        run_to(88);
        chk("t2_e88_retry", retry_cnt, 2);
        run_to(300 * 44 + 20);
        chk("t2_saturated", retry_cnt, 255);
        chk("t2_model_pin", m_retry, 255);

        // Random lock activity with occasional clears and resets.
        do_reset();
        left = 0;
        for (int i = 0; i < 4000; i++) begin
            if (left <= 0) begin
                locked_in = ($urandom_range(0, 3) != 0);
                left = locked_in ? $urandom_range(1, 60) : $urandom_range(1, 6);
            end
            left--;
            clr_lost = ($urandom_range(0, 19) == 0);
            reset    = ($urandom_range(0, 499) == 0);
            tick();
        end
        reset    = 1'b0;
        clr_lost = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
